// File: rtl/leaf_renderer_pkg.sv
// rtl/leaf_renderer_pkg.sv - shared display constants, colour type and leaf palette
// Purpose: constants shared by the VGA timing stage and the leaf renderer.
// Ports: none (package).
package leaf_renderer_pkg;

  localparam int H_ACTIVE   = 800;
  localparam int V_ACTIVE   = 600;
  localparam int SPRITE_DIM = 16;
  localparam int X_W        = 11;
  localparam int Y_W        = 10;

  typedef logic [5:0] color_t;
  typedef logic [1:0] texel_t;

  localparam color_t COLOR_BLACK    = 6'b000000;
  localparam color_t PAL_DARK_GREEN = 6'b001000;
  localparam color_t PAL_LEAF_GREEN = 6'b011100;
  localparam color_t PAL_STEM_BROWN = 6'b101000;

  localparam texel_t TEXEL_CLEAR = 2'd0;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           flip;
  } sprite_pos_t;

  // Code 0 is transparent and never reaches this lookup in practice.
  function automatic color_t palette(input texel_t code);
    case (code)
      2'd1:    palette = PAL_DARK_GREEN;
      2'd2:    palette = PAL_LEAF_GREEN;
      2'd3:    palette = PAL_STEM_BROWN;
      default: palette = COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/leaf_renderer_if.sv
// rtl/leaf_renderer_if.sv - sprite position request channel
// Purpose: valid/ready channel carrying a requested sprite position.
// Signals: pos_x, pos_y, pos_flip, pos_valid (game logic -> renderer),
//          pos_ready (renderer -> game logic).
interface leaf_renderer_if;
  import leaf_renderer_pkg::*;

  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           pos_flip;
  logic           pos_valid;
  logic           pos_ready;

  modport master (output pos_x, pos_y, pos_flip, pos_valid, input pos_ready);
  modport slave  (input pos_x, pos_y, pos_flip, pos_valid, output pos_ready);
endinterface

// File: rtl/leaf_sprite_rom.sv
// rtl/leaf_sprite_rom.sv - combinational 16x16 2-bit leaf bitmap
// Purpose: fixed texel lookup for the leaf sprite.
// Ports: ty_i[3:0] row, tx_i[3:0] column in, code_o[1:0] texel code out.
module leaf_sprite_rom
  import leaf_renderer_pkg::*;
(
  input  logic [3:0] ty_i,
  input  logic [3:0] tx_i,
  output texel_t     code_o
);

  logic [31:0] row;

  // Each row packs 16 texels, column 0 in the two most significant bits.
  always_comb begin
    row = '0;
    case (ty_i)
      4'd0:  row = 32'h001F_A400;
      4'd1:  row = 32'h006B_F900;
      4'd2:  row = 32'h01AA_EA40;
      4'd3:  row = 32'h06AA_EA90;
      4'd4:  row = 32'h1AA6_EAA4;
      4'd5:  row = 32'h6A9A_E6A9;
      4'd6:  row = 32'h6A6A_E9A9;
      4'd7:  row = 32'h69AA_EA69;
      4'd8:  row = 32'h66AA_EA99;
      4'd9:  row = 32'h1AAA_EAA4;
      4'd10: row = 32'h06AA_EA90;
      4'd11: row = 32'h01AA_EA40;
      4'd12: row = 32'h006A_E900;
      4'd13: row = 32'h001A_E400;
      4'd14: row = 32'h0003_C000;
      4'd15: row = 32'h0000_F000;
    endcase
  end

  // Column tx sits 2*(15-tx) bits above the LSB; 15-tx is simply ~tx.
  assign code_o = texel_t'(row >> {~tx_i, 1'b0});

endmodule

// File: rtl/leaf_renderer.sv
// rtl/leaf_renderer.sv - leaf sprite compositor over a background colour
// Purpose: returns the RRGGBB pixel for the look-ahead coordinate one clock
//          later; sprite position updates commit only at the frame boundary.
// Ports: clk, rst (async active-low), en, nextH, nextV, nextActive, bg_color in;
//        pos (position request channel, slave side);
//        pixel (registered RRGGBB), frame_tick (one-cycle pulse) out.
module leaf_renderer
  import leaf_renderer_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [X_W-1:0] nextH,
  input  logic [Y_W-1:0] nextV,
  input  logic           nextActive,
  input  color_t         bg_color,
  leaf_renderer_if.slave pos,
  output color_t         pixel,
  output logic           frame_tick
);

  localparam int unsigned SPAN = SPRITE_DIM << SCALE_SHIFT;

  sprite_pos_t    live_q, live_d;
  sprite_pos_t    pend_q, pend_d;
  logic           pend_full_q, pend_full_d;
  color_t         pixel_q, pixel_d;
  logic           frame_tick_q;

  logic           accept;
  logic           boundary;
  logic           hit;
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  logic [3:0]     tx_raw, tx, ty;
  texel_t         code;

  assign pos.pos_ready = !pend_full_q;
  assign accept        = pos.pos_valid && !pend_full_q;
  assign boundary      = (nextV == Y_W'(V_ACTIVE)) && (nextH == '0);

  // Accept and commit never coincide: accept needs an empty slot, commit a full one.
  always_comb begin
    live_d      = live_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      live_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d.x    = pos.pos_x;
      pend_d.y    = pos.pos_y;
      pend_d.flip = pos.pos_flip;
      pend_full_d = 1'b1;
    end
  end

  // The >= terms stop modular wrap of dx/dy from drawing on the opposite edge.
  assign dx  = nextH - live_q.x;
  assign dy  = nextV - live_q.y;
  assign hit = nextActive && (nextH >= live_q.x) && (nextV >= live_q.y) &&
               (dx < X_W'(SPAN)) && (dy < Y_W'(SPAN));

  assign tx_raw = 4'(dx >> SCALE_SHIFT);
  assign ty     = 4'(dy >> SCALE_SHIFT);
  assign tx     = live_q.flip ? ~tx_raw : tx_raw;

  leaf_sprite_rom u_rom (
    .ty_i   (ty),
    .tx_i   (tx),
    .code_o (code)
  );

  always_comb begin
    pixel_d = bg_color;
    if (!en || !nextActive) begin
      pixel_d = COLOR_BLACK;
    end else if (hit && (code != TEXEL_CLEAR)) begin
      pixel_d = palette(code);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      pixel_q      <= COLOR_BLACK;
      frame_tick_q <= 1'b0;
    end else begin
      live_q       <= live_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      pixel_q      <= pixel_d;
      frame_tick_q <= boundary;
    end
  end

  assign pixel      = pixel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_leaf_renderer.sv
// tb/tb_leaf_renderer.sv - scoreboard bench for leaf_renderer
module tb_leaf_renderer;
  import leaf_renderer_pkg::*;

  localparam int SC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [10:0] nextH = '0;
  logic [9:0]  nextV = '0;
  logic        nextActive = 1'b0;
  logic [5:0]  bg_color = '0;
  logic [5:0]  pixel;
  logic        frame_tick;

  leaf_renderer_if pif ();

  leaf_renderer #(.SCALE_SHIFT(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .nextH      (nextH),
    .nextV      (nextV),
    .nextActive (nextActive),
    .bg_color   (bg_color),
    .pos        (pif),
    .pixel      (pixel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  logic [31:0] leaf_rows [16] = '{
    32'h001FA400, 32'h006BF900, 32'h01AAEA40, 32'h06AAEA90,
    32'h1AA6EAA4, 32'h6A9AE6A9, 32'h6A6AE9A9, 32'h69AAEA69,
    32'h66AAEA99, 32'h1AAAEAA4, 32'h06AAEA90, 32'h01AAEA40,
    32'h006AE900, 32'h001AE400, 32'h0003C000, 32'h0000F000
  };

  typedef struct {
    int         due;
    logic [5:0] pix;
    bit         tick;
    bit         rdy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: sprite on screen plus at most one waiting request.
  int m_lx = 0, m_ly = 0;
  bit m_flip = 0;
  int p_x = 0, p_y = 0;
  bit p_flip = 0, p_full = 0;

  bit         g_en = 1;
  logic [5:0] g_bg = '0;
  bit         req_valid = 0;
  int         req_x = 0, req_y = 0;
  bit         req_flip = 0;

  always @(posedge clk) cyc++;

  function automatic void check(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, want, cyc);
    end
  endfunction

  function automatic logic [5:0] exp_pix(int h, int v, bit act, bit e, logic [5:0] bg);
    int span, tx, ty, code;
    span = 16 << SC;
    if (!e || !act) return 6'b000000;
    if (h >= m_lx && v >= m_ly && (h - m_lx) < span && (v - m_ly) < span) begin
      tx = (h - m_lx) >> SC;
      ty = (v - m_ly) >> SC;
      if (m_flip) tx = 15 - tx;
      code = int'((leaf_rows[ty] >> (30 - 2 * tx)) & 32'd3);
      if (code == 1) return 6'b001000;
      if (code == 2) return 6'b011100;
      if (code == 3) return 6'b101000;
    end
    return bg;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pixel", int'(pixel), int'(e.pix));
      check("frame_tick", int'(frame_tick), int'(e.tick));
      check("pos_ready", int'(pif.pos_ready), int'(e.rdy));
    end
  end

  // Called just after a rising edge; presents one coordinate and advances the model.
  task automatic step(input int h, input int v, input bit act);
    exp_t e;
    bit   acc, bnd;
    nextH         = 11'(h);
    nextV         = 10'(v);
    nextActive    = act;
    en            = g_en;
    bg_color      = g_bg;
    pif.pos_valid = req_valid;
    pif.pos_x     = 11'(req_x);
    pif.pos_y     = 10'(req_y);
    pif.pos_flip  = req_flip;
    acc = req_valid && !p_full;
    bnd = (v == V_ACTIVE) && (h == 0);
    e.due  = cyc + 1;
    e.pix  = exp_pix(h, v, act, g_en, g_bg);
    e.tick = bnd;
    if (bnd && p_full) begin
      m_lx = p_x; m_ly = p_y; m_flip = p_flip; p_full = 0;
    end
    if (acc) begin
      p_x = req_x; p_y = req_y; p_flip = req_flip; p_full = 1;
    end
    e.rdy = !p_full;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (acc) req_valid = 0;
  endtask

  task automatic request(input int x, input int y, input bit fl);
    req_valid = 1; req_x = x; req_y = y; req_flip = fl;
  endtask

  task automatic frame_boundary();
    step(0, V_ACTIVE, 0);
  endtask

  task automatic sweep(input int x, input int y);
    for (int v = y - 1; v <= y + 32; v++) begin
      for (int h = x - 2; h <= x + 33; h++) begin
        if (h < 0 || v < 0 || h > 1055 || v > 627) continue;
        step(h, v, (h < H_ACTIVE) && (v < V_ACTIVE));
      end
    end
  endtask

  initial begin
    pif.pos_valid = 0; pif.pos_x = '0; pif.pos_y = '0; pif.pos_flip = 0;
    #2 rst = 0;
    #1;
    check("reset_pixel", int'(pixel), 0);
    check("reset_pos_ready", int'(pif.pos_ready), 1);
    check("reset_frame_tick", int'(frame_tick), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    g_en = 1; g_bg = 6'b000011;

    step(100, 100, 1);
    sweep(0, 0);

    // Request mid-frame, commit at boundary, inspect next frame.
    request(200, 150, 0);
    for (int i = 0; i < 8; i++) step(300 + i, 20, 1);
    frame_boundary();
    for (int i = 0; i < 4; i++) step(900 + i, 600, 0);
    sweep(200, 150);

    // Back-to-back requests: the second waits for the first commit.
    request(300, 400, 0);
    step(10, 10, 1);
    request(320, 410, 0);
    for (int i = 0; i < 6; i++) step(50 + i, 10, 1);
    frame_boundary();
    for (int i = 0; i < 3; i++) step(60 + i, 10, 1);
    sweep(300, 400);
    frame_boundary();
    sweep(320, 410);

    // Right-edge clipping with no wrap onto column 0.
    request(790, 100, 0);
    step(5, 5, 1);
    frame_boundary();
    sweep(790, 100);
    for (int v = 100; v < 133; v++)
      for (int h = 0; h < 4; h++) step(h, v, 1);

    // Mirrored sprite over the same location as the unflipped one.
    request(200, 150, 1);
    step(5, 5, 1);
    frame_boundary();
    sweep(200, 150);

    // Output enable dropped mid-line.
    for (int h = 196; h < 236; h++) begin
      g_en = !(h >= 210 && h < 220);
      step(h, 152, 1);
    end
    g_en = 1;

    // Randomised traffic around the live sprite.
    for (int i = 0; i < 4000; i++) begin
      int h, v;
      bit act;
      if (!req_valid && $urandom_range(0, 24) == 0)
        request($urandom_range(0, 820), $urandom_range(0, 620), 1'($urandom_range(0, 1)));
      g_bg = 6'($urandom);
      g_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) < 3) begin
        frame_boundary();
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          h = $urandom_range(0, 1055);
          v = $urandom_range(0, 627);
        end else begin
          h = m_lx + $urandom_range(0, 40) - 4;
          v = m_ly + $urandom_range(0, 40) - 4;
          if (h < 0) h = 0;
          if (v < 0) v = 0;
          if (h > 1055) h = 1055;
          if (v > 627) v = 627;
        end
        act = (h < H_ACTIVE) && (v < V_ACTIVE) && ($urandom_range(0, 15) != 0);
        step(h, v, act);
      end
    end
    g_en = 1; g_bg = 6'b000011;
    req_valid = 0;

    // Asynchronous reset mid-frame with a request waiting in the slot.
    frame_boundary();
    request(500, 300, 0);
    step(400, 200, 1);
    step(401, 200, 1);
    #2 rst = 0;
    #1;
    check("async_reset_pixel", int'(pixel), 0);
    check("async_reset_pos_ready", int'(pif.pos_ready), 1);
    check("async_reset_frame_tick", int'(frame_tick), 0);
    exp_q.delete();
    m_lx = 0; m_ly = 0; m_flip = 0; p_full = 0; req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    sweep(0, 0);
    frame_boundary();
    sweep(500, 300);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leaf_renderer.md
# leaf_renderer

Pixel source for the VGA output stage: takes the timing stage's look-ahead coordinates (nextH, nextV, nextActive) and returns the 6-bit RRGGBB pixel one clock later. It composites one 16×16, 2-bit-per-texel sprite (the leaf), scaled by a power of two, over a programmable background colour. Sprite position arrives from game logic through a valid/ready handshake. The new position is committed only at the frame boundary, so a frame never tears.

## Interface
- H_ACTIVE, 800: visible pixels per line.
- V_ACTIVE, 600: visible lines per frame.
- SCALE_SHIFT, 1: sprite magnification is 2^SCALE_SHIFT. Legal values are 0–2.

- clk  in  1  pixel clock, the same clock as the VGA stage.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  output enable. When low, pixel is forced to 0; position logic keeps running.
- nextH  in  11  horizontal coordinate of the pixel needed next cycle.
- nextV  in  10  vertical coordinate of the pixel needed next cycle.
- nextActive  in  1  nextH/nextV lie in the visible area.
- bg_color  in  6  background RRGGBB, sampled every cycle.
- pos_x  in  11  requested sprite left edge.
- pos_y  in  10  requested sprite top edge.
- pos_flip  in  1  mirror the sprite horizontally.
- pos_valid  in  1  position request valid.
- pos_ready  out  1  pending slot is empty.
- pixel  out  6  RRGGBB to the VGA stage, registered.
- frame_tick  out  1  one-cycle pulse when a frame boundary passes.

## Operation
- Live registers: live_x, live_y, live_flip. Reset value is 0 for all three.
- Pending slot: pend_x, pend_y, pend_flip, plus pend_full. Reset value of pend_full is 0.
- Accept: pos_valid && pos_ready loads the pending slot and sets pend_full.
  - pos_ready = !pend_full.
- Frame boundary is the cycle where nextV == V_ACTIVE and nextH == 0, i.e. the first blanking line.
  - If pend_full, copy pend → live and clear pend_full.
  - frame_tick is asserted on the next cycle whether or not a commit happened.
  - A frame boundary in the same cycle as an accept is only possible while the slot is empty. The accepted value lands in pending and is not committed until the next boundary.
- Hit test, combinational on the next* inputs:
  - dx = nextH − live_x (11-bit); dy = nextV − live_y (10-bit).
  - hit = nextActive && nextH ≥ live_x && nextV ≥ live_y && dx < (16 << SCALE_SHIFT) && dy < (16 << SCALE_SHIFT).
  - Comparisons are unsigned. A sprite that runs past the right or bottom edge is clipped; no wrap-around onto the opposite edge.
- Texel address:
  - tx = dx >> SCALE_SHIFT (4 bits); ty = dy >> SCALE_SHIFT (4 bits).
  - If live_flip, tx is replaced by 15 − tx.
- Texel lookup: code = rom(ty, tx), 2 bits. Palette:
  - 0 = transparent
  - 1 = 6'b001000 (dark green)
  - 2 = 6'b011100 (leaf green)
  - 3 = 6'b101000 (brown stem)
- Output register, priority in this order:
  - !en or !nextActive → 0
  - hit && code ≠ 0 → palette colour
  - otherwise → bg_color
- Reset values: pixel 0, frame_tick 0, pos_ready 1.
- Reset asserted mid-frame clears everything asynchronously, including any pending position. Operation resumes with the first rising edge after release.

## Timing
- Latency is exactly 1 clock from next* to pixel. There is no pipelining beyond the output register, so the ROM is combinational.
- pos_ready goes low the cycle after an accept. It returns high the cycle after the commit.
- A position accepted during frame N is first visible in frame N+1, or in frame N+2 if it was accepted after frame N's boundary cycle.
- frame_tick rises one cycle after the boundary cycle and lasts one cycle. The interval between ticks is exactly one frame period.

## Structure
- Shared package, also used by the VGA stage: H_ACTIVE, V_ACTIVE, the 6-bit colour type, palette constants, SPRITE_DIM = 16.
- Sub-module leaf_sprite_rom: combinational 256×2 lookup, inputs ty[3:0] and tx[3:0], output code[1:0]. The bitmap is fixed in a case statement.
- Top-level holds the handshake, commit logic, hit test and output register.

## Test plan
- Reset, then release with en=1, bg_color=6'b000011, live position (0,0), nextH=100, nextV=100, nextActive=1 → pixel=6'b000011 one cycle later; pos_ready=1; frame_tick=0.
- Accept pos (200,150) in the visible area, then sweep to the boundary (nextV=600, nextH=0) → pos_ready=0 until the commit; frame_tick pulses once. Next frame, nextH=200..231 on line 150 (SCALE_SHIFT=1) match the ROM row 0 colours; nextH=232 → bg_color.
- Present two requests back-to-back → second is stalled (pos_ready=0) until the commit, then accepted. The first request is displayed in frame N+1, the second in frame N+2.
- Commit pos_x=790 → columns 790–799 show the sprite, nothing appears at column 0 of the same or next line, and nothing is drawn during nextActive=0.
- Commit pos_flip=1, compare against the unflipped frame → pixel at dx=k equals the unflipped pixel at dx=31−k (SCALE_SHIFT=1).
- en=0 mid-line → pixel=0 the next cycle. Pull rst low mid-frame with a pending request → pixel=0, pos_ready=1, and the live position reads back (0,0) without waiting for a clock edge.
